// File: rtl/vram_copy_engine.sv
// Back-to-front VRAM copier run during vertical blank, 4 cycles per byte.
// Optional dirty gating when VRAM_COPY_DIRTY_EN is defined.
module vram_copy_engine #(
   parameter int COPY_BYTES = 4800,
   parameter int ADDR_W     = 13
) (
   input  logic              pclk,
   input  logic              rst_low,
   input  logic              vblank,
   input  logic              cpu_wrote,
   output logic              copy_in_progress,
   output logic [ADDR_W-1:0] back_vram_addr,
   output logic              back_vram_rd_low,
   input  logic [7:0]        back_vram_data,
   output logic [ADDR_W-1:0] front_vram_addr,
   output logic [7:0]        front_vram_data,
   output logic              front_vram_wr_low
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GUARD,
      S_RD_ADDR,
      S_RD_LATCH,
      S_WR_PULSE,
      S_WR_END
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COPY_BYTES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        data_q, data_d;
   logic              vblank_q, vblank_d;
   logic              abort_q, abort_d;
   logic              rise, fall;
   logic              start_ok;
   logic              enter_guard;
   logic              abort_evt;
   logic              back_drv;
   logic              front_drv;
   logic              rd_act;

   assign rise = vblank & ~vblank_q;
   assign fall = ~vblank & vblank_q;

`ifdef VRAM_COPY_DIRTY_EN
   logic dirty_q, dirty_d;

   assign start_ok = dirty_q;

   // A CPU write landing on the clear cycle must not be lost.
   always_comb begin
      dirty_d = dirty_q;
      if (enter_guard)
         dirty_d = 1'b0;
      if (abort_evt)
         dirty_d = 1'b1;
      if (cpu_wrote)
         dirty_d = 1'b1;
   end

   always_ff @(posedge pclk or negedge rst_low) begin
      if (!rst_low)
         dirty_q <= 1'b1;
      else
         dirty_q <= dirty_d;
   end
`else
   logic unused_cpu_wrote;

   assign unused_cpu_wrote = cpu_wrote;
   assign start_ok         = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      data_d      = data_q;
      abort_d     = abort_q;
      vblank_d    = vblank;
      enter_guard = 1'b0;
      abort_evt   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            idx_d   = '0;
            abort_d = 1'b0;
            if (rise && start_ok) begin
               state_d     = S_GUARD;
               enter_guard = 1'b1;
            end
         end
         S_GUARD: begin
            if (fall) begin
               state_d   = S_IDLE;
               abort_evt = 1'b1;
            end else begin
               state_d = S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            if (fall) begin
               abort_d   = 1'b1;
               abort_evt = 1'b1;
            end
            state_d = S_RD_LATCH;
         end
         S_RD_LATCH: begin
            if (fall) begin
               abort_d   = 1'b1;
               abort_evt = 1'b1;
            end
            data_d  = back_vram_data;
            state_d = S_WR_PULSE;
         end
         S_WR_PULSE: begin
            if (fall) begin
               abort_d   = 1'b1;
               abort_evt = 1'b1;
            end
            state_d = S_WR_END;
         end
         S_WR_END: begin
            if (fall)
               abort_evt = 1'b1;
            // A fall on this very cycle still ends after the current byte.
            if (idx_q == LAST_IDX || abort_q || fall) begin
               state_d = S_IDLE;
               idx_d   = '0;
               abort_d = 1'b0;
            end else begin
               state_d = S_RD_ADDR;
               idx_d   = idx_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            abort_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst_low) begin
      if (!rst_low) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         data_q   <= '0;
         vblank_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         vblank_q <= vblank_d;
         abort_q  <= abort_d;
      end
   end

   assign copy_in_progress = (state_q != S_IDLE);

   assign rd_act    = (state_q == S_RD_ADDR) || (state_q == S_RD_LATCH);
   assign front_drv = (state_q == S_WR_PULSE) || (state_q == S_WR_END);
   assign back_drv  = rd_act || front_drv;

   assign back_vram_addr   = back_drv ? idx_q : {ADDR_W{1'bz}};
   assign back_vram_rd_low = back_drv ? ~rd_act : 1'bz;

   assign front_vram_addr   = front_drv ? idx_q : {ADDR_W{1'bz}};
   assign front_vram_data   = front_drv ? data_q : 8'bz;
   assign front_vram_wr_low = ~(state_q == S_WR_PULSE);

endmodule

// File: tb/tb_vram_copy_engine.sv
// Directed bench for vram_copy_engine with back/front VRAM and CPU bus models.
// Dirty-gating steps run only when VRAM_COPY_DIRTY_EN is defined.
module tb_vram_copy_engine;

   localparam int AW = 13;
   localparam logic [AW-1:0] SENT_BA = 13'h1ABC;
   localparam logic [AW-1:0] SENT_FA = 13'h0F0F;
   localparam logic [7:0]    SENT_FD = 8'hC3;

   logic pclk      = 1'b0;
   logic clk_en    = 1'b0;
   logic rst_low   = 1'b0;
   logic vblank    = 1'b0;
   logic cpu_wrote = 1'b0;

   wire          copy_in_progress;
   wire [AW-1:0] back_vram_addr;
   wire          back_vram_rd_low;
   wire [7:0]    back_vram_data;
   wire [AW-1:0] front_vram_addr;
   wire [7:0]    front_vram_data;
   wire          front_vram_wr_low;
   wire          cpu_drive;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int wr_cnt = 0;

   logic [7:0]    front_mem [0:8191];
   logic [AW-1:0] wr_log    [0:8191];

   // CPU side drives sentinels whenever the copier does not own the buses.
   assign cpu_drive        = ~copy_in_progress;
   assign back_vram_addr   = cpu_drive ? SENT_BA : {AW{1'bz}};
   assign back_vram_rd_low = cpu_drive ? 1'b0 : 1'bz;
   assign front_vram_addr  = cpu_drive ? SENT_FA : {AW{1'bz}};
   assign front_vram_data  = cpu_drive ? SENT_FD : 8'bz;
   assign back_vram_data   = back_vram_addr[7:0] ^ 8'h5A;

   vram_copy_engine #(
      .COPY_BYTES(4800),
      .ADDR_W    (AW)
   ) dut (
      .pclk             (pclk),
      .rst_low          (rst_low),
      .vblank           (vblank),
      .cpu_wrote        (cpu_wrote),
      .copy_in_progress (copy_in_progress),
      .back_vram_addr   (back_vram_addr),
      .back_vram_rd_low (back_vram_rd_low),
      .back_vram_data   (back_vram_data),
      .front_vram_addr  (front_vram_addr),
      .front_vram_data  (front_vram_data),
      .front_vram_wr_low(front_vram_wr_low)
   );

   always #5 if (clk_en) pclk = ~pclk;

   always @(posedge pclk) begin
      cyc <= cyc + 1;
      if (front_vram_wr_low === 1'b0 && copy_in_progress === 1'b1) begin
         front_mem[front_vram_addr] <= front_vram_data;
         wr_log[wr_cnt[12:0]]       <= front_vram_addr;
         wr_cnt                     <= wr_cnt + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cip(input logic val, input int max, output int n);
      n = 0;
      while (copy_in_progress !== val && n < max) begin
         step(1);
         n++;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cip"}, {31'd0, copy_in_progress}, 32'd0);
      chk({tag, "_wr_low"}, {31'd0, front_vram_wr_low}, 32'd1);
      chk({tag, "_back_addr"}, {19'd0, back_vram_addr}, {19'd0, SENT_BA});
      chk({tag, "_back_rd"}, {31'd0, back_vram_rd_low}, 32'd0);
      chk({tag, "_front_addr"}, {19'd0, front_vram_addr}, {19'd0, SENT_FA});
      chk({tag, "_front_data"}, {24'd0, front_vram_data}, {24'd0, SENT_FD});
   endtask

   initial begin
      int n;
      int c0;
      int bad;
      logic any;

      // Reset with no clock running
      rst_low = 1'b0;
      #2;
      chk_idle("reset");

      clk_en = 1'b1;
      step(3);
      rst_low = 1'b1;
      step(2);

      // Full copy with per-phase bus checks on the first bytes
      c0     = wr_cnt;
      vblank = 1'b1;
      wait_cip(1'b1, 5, n);
      chk("start_latency", n, 1);
      chk("guard_wr_low", {31'd0, front_vram_wr_low}, 32'd1);
      step(1);
      chk("rd_addr_b0", {19'd0, back_vram_addr}, 32'd0);
      chk("rd_strobe_b0", {31'd0, back_vram_rd_low}, 32'd0);
      chk("rd_wr_low_b0", {31'd0, front_vram_wr_low}, 32'd1);
      step(1);
      chk("latch_strobe_b0", {31'd0, back_vram_rd_low}, 32'd0);
      step(1);
      chk("wp_rd_b0", {31'd0, back_vram_rd_low}, 32'd1);
      chk("wp_wr_low_b0", {31'd0, front_vram_wr_low}, 32'd0);
      chk("wp_addr_b0", {19'd0, front_vram_addr}, 32'd0);
      chk("wp_data_b0", {24'd0, front_vram_data}, 32'h5A);
      step(1);
      chk("we_wr_low_b0", {31'd0, front_vram_wr_low}, 32'd1);
      chk("we_data_b0", {24'd0, front_vram_data}, 32'h5A);
      step(1);
      chk("rd_addr_b1", {19'd0, back_vram_addr}, 32'd1);
      wait_cip(1'b0, 20000, n);
      chk("copy_end", {31'd0, copy_in_progress}, 32'd0);
      chk("copy_len", 5 + n, 19201);
      chk("full_wr_cnt", wr_cnt - c0, 4800);
      bad = 0;
      for (int i = 0; i < 4800; i++) begin
         if (front_mem[i] !== (i[7:0] ^ 8'h5A))
            bad++;
         if (wr_log[c0 + i] !== i[12:0])
            bad++;
      end
      chk("full_data", bad, 0);

      // Level held high must not start another copy
      any = 1'b0;
      for (int i = 0; i < 19300; i++) begin
         step(1);
         any = any | copy_in_progress;
      end
      chk("retrigger", {31'd0, any}, 32'd0);
      chk("retrigger_wr_cnt", wr_cnt - c0, 4800);
      chk_idle("post_copy");
      vblank = 1'b0;
      step(3);

`ifdef VRAM_COPY_DIRTY_EN
      vblank = 1'b1;
      any    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         any = any | copy_in_progress;
      end
      chk("dirty_block", {31'd0, any}, 32'd0);
      vblank = 1'b0;
      step(2);
      cpu_wrote = 1'b1;
      step(1);
      cpu_wrote = 1'b0;
      step(2);
`endif

      // Abort: vblank low during cycle 1000 of the copy
      c0     = wr_cnt;
      vblank = 1'b1;
      wait_cip(1'b1, 5, n);
      chk("abort_start", {31'd0, copy_in_progress}, 32'd1);
      step(1000);
      vblank = 1'b0;
      wait_cip(1'b0, 8, n);
      chk("abort_end", {31'd0, copy_in_progress}, 32'd0);
      chk("abort_latency_ok", {31'd0, (n <= 4)}, 32'd1);
      chk("abort_wr_cnt", wr_cnt - c0, 250);
      chk("abort_last_addr", {19'd0, wr_log[c0 + 249]}, 32'd249);
      chk("abort_byte249", {24'd0, front_mem[249]}, 32'hA3);
      step(3);

      // Reset while reading idx 100
      c0     = wr_cnt;
      vblank = 1'b1;
      wait_cip(1'b1, 5, n);
      chk("rst_mid_start", {31'd0, copy_in_progress}, 32'd1);
      step(402);
      chk("rst_mid_idx", {19'd0, back_vram_addr}, 32'd100);
      rst_low = 1'b0;
      vblank  = 1'b0;
      #1;
      chk_idle("rst_mid");
      chk("rst_mid_wr_cnt", wr_cnt - c0, 100);
      step(2);
      rst_low = 1'b1;
      step(2);

      // Next vblank restarts from idx 0
      c0     = wr_cnt;
      vblank = 1'b1;
      wait_cip(1'b1, 5, n);
      chk("restart_start", {31'd0, copy_in_progress}, 32'd1);
      step(12);
      chk("restart_wr_cnt", wr_cnt - c0, 3);
      chk("restart_first", {19'd0, wr_log[c0]}, 32'd0);
      chk("restart_second", {19'd0, wr_log[c0 + 1]}, 32'd1);
      vblank = 1'b0;
      wait_cip(1'b0, 8, n);
      chk("restart_abort", {31'd0, copy_in_progress}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
